// File: rtl/rx_pkg.sv
// Shared USB RX constants and the bit-timer state encoding.
// Used by the bit timer, the RX shift register and the RX control FSM.
package rx_pkg;

  localparam int CLKS_PER_BIT  = 8;
  localparam int BITS_PER_BYTE = 8;

  typedef logic [0:0] timer_state_t;

  localparam timer_state_t ST_IDLE   = 1'b0;
  localparam timer_state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/rx_phase_counter.sv
// Modulo-MODULUS up-counter with synchronous clear, load-zero and enable.
// Priority: clear, then load-zero, then enable.
module rx_phase_counter #(
  parameter int MODULUS = 8,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             load_zero_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i || load_zero_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rx_bit_timer.sv
// USB RX bit-timing controller: recovers the bit phase from line edges,
// issues the per-bit sample strobe, gates stuffed bits and counts bytes.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = rx_pkg::CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = rx_pkg::BITS_PER_BYTE
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               rcving,
  input  logic                               d_edge,
  input  logic                               ignore_bit,
  output logic                               sample_strobe,
  output logic                               shift_enable,
  output logic                               byte_received,
  output logic [$clog2(BITS_PER_BYTE+1)-1:0] bit_count
);

  import rx_pkg::*;

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(BITS_PER_BYTE + 1);

  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(SAMPLE_POINT);
  localparam logic [CW-1:0] LAST_BIT     = CW'(BITS_PER_BYTE - 1);

  timer_state_t  state_q;
  timer_state_t  state_d;
  logic          byte_rcvd_q;
  logic          byte_rcvd_d;
  logic          active;
  logic          counters_clear;
  logic [PW-1:0] phase;
  logic [CW-1:0] bit_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rcving)  state_d = ST_ACTIVE;
      ST_ACTIVE: if (!rcving) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      byte_rcvd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_rcvd_q <= byte_rcvd_d;
    end
  end

  assign active = (state_q == ST_ACTIVE);

  // Dropping rcving clears both counters on the same edge that leaves ACTIVE,
  // so a partial byte is simply discarded.
  assign counters_clear = !active || !rcving;

  rx_phase_counter #(
    .MODULUS (CLKS_PER_BIT),
    .WIDTH   (PW)
  ) u_phase (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_i     (counters_clear),
    .load_zero_i (d_edge),
    .enable_i    (active),
    .count_o     (phase)
  );

  rx_phase_counter #(
    .MODULUS (BITS_PER_BYTE),
    .WIDTH   (CW)
  ) u_bits (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_i     (counters_clear),
    .load_zero_i (1'b0),
    .enable_i    (shift_enable),
    .count_o     (bit_cnt)
  );

  assign sample_strobe = active && (phase == SAMPLE_PHASE);
  assign shift_enable  = sample_strobe && !ignore_bit;

  // The completing shift still reports its byte even if rcving falls with it.
  assign byte_rcvd_d   = shift_enable && (bit_cnt == LAST_BIT);
  assign byte_received = byte_rcvd_q;
  assign bit_count     = bit_cnt;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: a cycle-indexed vector table plus a
// hand-written asynchronous-reset sequence.
module tb_rx_bit_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rcving;
  logic       d_edge;
  logic       ignore_bit;
  logic       sample_strobe;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rx_bit_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rcving        (rcving),
    .d_edge        (d_edge),
    .ignore_bit    (ignore_bit),
    .sample_strobe (sample_strobe),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .bit_count     (bit_count)
  );

  typedef struct {
    int         cyc;
    logic       rcv;
    logic       edg;
    logic       ign;
    logic       strobe;
    logic       shift;
    logic       byte_r;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int c, input logic r, input logic e, input logic i,
                     input logic s, input logic sh, input logic b, input logic [3:0] n);
    vec_t v;
    v.cyc = c; v.rcv = r; v.edg = e; v.ign = i;
    v.strobe = s; v.shift = sh; v.byte_r = b; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic s, input logic sh,
                         input logic b, input logic [3:0] n);
    chk({tag, " sample_strobe"}, cyc, 32'(sample_strobe), 32'(s));
    chk({tag, " shift_enable"},  cyc, 32'(shift_enable),  32'(sh));
    chk({tag, " byte_received"}, cyc, 32'(byte_received), 32'(b));
    chk({tag, " bit_count"},     cyc, 32'(bit_count),     32'(n));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   vi;
    int   last_cyc;
    logic rcv_lvl;

    //  cyc rcv edg ign | strobe shift byte cnt
    add(  0, 1, 0, 0,   0, 0, 0, 0);
    add(  3, 1, 0, 0,   0, 0, 0, 0);
    add(  4, 1, 0, 0,   1, 1, 0, 0);
    add(  5, 1, 0, 0,   0, 0, 0, 1);
    add( 12, 1, 0, 0,   1, 1, 0, 1);
    add( 20, 1, 0, 1,   1, 0, 0, 2);
    add( 21, 1, 0, 1,   0, 0, 0, 2);
    add( 28, 1, 0, 0,   1, 1, 0, 2);
    add( 60, 1, 0, 0,   1, 1, 0, 6);
    add( 61, 1, 0, 0,   0, 0, 0, 7);
    add( 68, 1, 0, 0,   1, 1, 0, 7);
    add( 69, 1, 0, 0,   0, 0, 1, 0);
    add( 70, 1, 0, 0,   0, 0, 0, 0);
    add( 71, 1, 1, 0,   0, 0, 0, 0);
    add( 72, 1, 0, 0,   0, 0, 0, 0);
    add( 74, 1, 0, 0,   0, 0, 0, 0);
    add( 75, 1, 0, 0,   1, 1, 0, 0);
    add( 76, 1, 0, 0,   0, 0, 0, 1);
    add( 83, 1, 1, 0,   1, 1, 0, 1);
    add( 84, 1, 0, 0,   0, 0, 0, 2);
    add( 86, 1, 0, 0,   0, 0, 0, 2);
    add( 87, 1, 0, 0,   1, 1, 0, 2);
    add( 92, 1, 1, 0,   0, 0, 0, 3);
    add( 95, 1, 0, 0,   0, 0, 0, 3);
    add( 96, 1, 0, 0,   1, 1, 0, 3);
    add(104, 1, 0, 0,   1, 1, 0, 4);
    add(105, 0, 0, 0,   0, 0, 0, 5);
    add(106, 0, 0, 0,   0, 0, 0, 0);
    add(108, 0, 0, 0,   0, 0, 0, 0);
    add(110, 1, 0, 0,   0, 0, 0, 0);
    add(114, 1, 0, 0,   1, 1, 0, 0);
    add(170, 1, 0, 0,   1, 1, 0, 7);
    add(171, 1, 0, 0,   0, 0, 1, 0);
    add(178, 1, 0, 0,   1, 1, 0, 0);
    add(234, 0, 0, 0,   1, 1, 0, 7);
    add(235, 0, 0, 0,   0, 0, 1, 0);
    add(236, 0, 0, 0,   0, 0, 0, 0);

    n_rst      = 1'b0;
    rcving     = 1'b0;
    d_edge     = 1'b0;
    ignore_bit = 1'b0;
    step();
    step();
    chk_all("reset", -1, 0, 0, 0, 4'd0);
    n_rst = 1'b1;
    step();

    vi       = 0;
    rcv_lvl  = 1'b0;
    last_cyc = vecs[vecs.size()-1].cyc;
    for (int c = 0; c <= last_cyc; c++) begin
      d_edge     = 1'b0;
      ignore_bit = 1'b0;
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        rcv_lvl    = vecs[vi].rcv;
        d_edge     = vecs[vi].edg;
        ignore_bit = vecs[vi].ign;
      end
      rcving = rcv_lvl;
      #2;
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        chk_all("vec", c, vecs[vi].strobe, vecs[vi].shift, vecs[vi].byte_r, vecs[vi].cnt);
        $display("vec cycle %0d: strobe=%0b shift=%0b byte=%0b count=%0d",
                 c, sample_strobe, shift_enable, byte_received, bit_count);
        vi++;
      end
      step();
    end

    // Asynchronous reset mid-byte, taken between edges during a strobe.
    d_edge     = 1'b0;
    ignore_bit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rcving = 1'b1;
      step();
    end
    #2;
    chk_all("pre-reset", 257, 1, 1, 0, 4'd2);
    #2;
    n_rst  = 1'b0;
    rcving = 1'b0;
    #1;
    chk_all("async reset", 257, 0, 0, 0, 4'd0);
    $display("async reset: strobe=%0b shift=%0b byte=%0b count=%0d",
             sample_strobe, shift_enable, byte_received, bit_count);
    step();
    step();
    n_rst = 1'b1;
    step();
    chk_all("post-release idle", 0, 0, 0, 0, 4'd0);

    rcving = 1'b1;
    step();
    step();
    step();
    chk("restart strobe early", 3, 32'(sample_strobe), 32'd0);
    step();
    chk("restart strobe", 4, 32'(sample_strobe), 32'd1);
    chk("restart count", 4, 32'(bit_count), 32'd0);
    $display("restart: strobe=%0b count=%0d", sample_strobe, bit_count);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
